// File: rtl/shift_pkg.sv
// Shared encodings for the multicycle shift unit: op codes, amount sources
// and FSM state constants.
package shift_pkg;

  typedef logic [2:0] op_t;
  typedef logic [1:0] amt_sel_t;
  typedef logic [1:0] state_t;

  localparam op_t OP_PASS = 3'b000;
  localparam op_t OP_SLL  = 3'b001;
  localparam op_t OP_SRL  = 3'b010;
  localparam op_t OP_SRA  = 3'b011;
  localparam op_t OP_ROR  = 3'b100;

  localparam amt_sel_t AMT_IMM   = 2'b00;
  localparam amt_sel_t AMT_REG   = 2'b01;
  localparam amt_sel_t AMT_CONST = 2'b10;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Codes 101-111 fall through to pass, so only these four do any shifting.
  function automatic logic is_shift_op(input op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_amt_unit_if.sv
// Request/result bundle between the datapath and the shift unit.
// The datapath drives through master, the shift unit sits on slave.
interface shift_amt_unit_if #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
);
  logic              start;
  logic [1:0]        amt_sel;
  logic [AMT_W-1:0]  shamt_imm;
  logic [AMT_W-1:0]  shamt_reg;
  logic [2:0]        op;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_out;
  logic [AMT_W-1:0]  amt_out;

  modport master (
    output start, amt_sel, shamt_imm, shamt_reg, op, data_in,
    input  busy, done, data_out, amt_out
  );

  modport slave (
    input  start, amt_sel, shamt_imm, shamt_reg, op, data_in,
    output busy, done, data_out, amt_out
  );
endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter: applies op by k bits (k may be 0).
// Used once per cycle by the iterative shift FSM.
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        op_i,
  input  logic [AMT_W-1:0]  k_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    case (op_i)
      OP_SLL:  data_o = data_i << k_i;
      OP_SRL:  data_o = data_i >> k_i;
      OP_SRA:  data_o = $signed(data_i) >>> k_i;
      // A left shift by the full width yields zero, so k=0 stays a no-op.
      OP_ROR:  data_o = (data_i >> k_i) | (data_i << (DATA_W - int'(k_i)));
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_amt_unit.sv
// Multicycle shift unit: selects a shift amount at start, then shifts the
// captured operand up to STEP bits per cycle until the amount is exhausted.
module shift_amt_unit
  import shift_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int AMT_W     = 5,
  parameter int STEP      = 1,
  parameter int CONST_AMT = 16
) (
  input logic             clk,
  input logic             reset_n,
  shift_amt_unit_if.slave bus
);

  localparam logic [AMT_W-1:0] STEP_W  = AMT_W'(STEP);
  localparam logic [AMT_W-1:0] CONST_W = AMT_W'(CONST_AMT);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  op_t               op_q, op_d;

  logic [AMT_W-1:0]  sel_amt;
  logic [AMT_W-1:0]  k;
  logic [DATA_W-1:0] step_res;

  always_comb begin
    case (bus.amt_sel)
      AMT_IMM: sel_amt = bus.shamt_imm;
      AMT_REG: sel_amt = bus.shamt_reg;
      default: sel_amt = CONST_W;
    endcase
  end

  assign k = (rem_q < STEP_W) ? rem_q : STEP_W;

  shift_step #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .k_i    (k),
    .data_o (step_res)
  );

  // IDLE and DONE share one arm: both accept start, which allows back-to-back ops.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      ST_SHIFT: begin
        data_d = step_res;
        rem_d  = rem_q - k;
        if (rem_q <= STEP_W) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        if (bus.start) begin
          data_d  = bus.data_in;
          op_d    = bus.op;
          amt_d   = sel_amt;
          rem_d   = sel_amt;
          state_d = ((sel_amt == '0) || !is_shift_op(bus.op)) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_PASS;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.data_out = data_q;
  assign bus.amt_out  = amt_q;

endmodule

// File: tb/tb_shift_amt_unit.sv
// Self-checking bench: two shift units (STEP=1 and STEP=4) driven by directed
// and random operations, compared against a whole-amount reference model.
module tb_shift_amt_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;

  shift_amt_unit_if #(.DATA_W(32), .AMT_W(5)) bus1 ();
  shift_amt_unit_if #(.DATA_W(32), .AMT_W(5)) bus4 ();

  shift_amt_unit #(.DATA_W(32), .AMT_W(5), .STEP(1), .CONST_AMT(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );
  shift_amt_unit #(.DATA_W(32), .AMT_W(5), .STEP(4), .CONST_AMT(16)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4)
  );

  always #5 clk = ~clk;

  logic        startR [2];
  logic [1:0]  selR   [2];
  logic [4:0]  immR   [2];
  logic [4:0]  regR   [2];
  logic [2:0]  opR    [2];
  logic [31:0] dataR  [2];
  logic        busyW  [2];
  logic        doneW  [2];
  logic [31:0] outW   [2];
  logic [4:0]  amtW   [2];

  assign bus1.start = startR[0];  assign bus4.start = startR[1];
  assign bus1.amt_sel = selR[0];  assign bus4.amt_sel = selR[1];
  assign bus1.shamt_imm = immR[0]; assign bus4.shamt_imm = immR[1];
  assign bus1.shamt_reg = regR[0]; assign bus4.shamt_reg = regR[1];
  assign bus1.op = opR[0];        assign bus4.op = opR[1];
  assign bus1.data_in = dataR[0]; assign bus4.data_in = dataR[1];
  assign busyW[0] = bus1.busy;    assign busyW[1] = bus4.busy;
  assign doneW[0] = bus1.done;    assign doneW[1] = bus4.done;
  assign outW[0] = bus1.data_out; assign outW[1] = bus4.data_out;
  assign amtW[0] = bus1.amt_out;  assign amtW[1] = bus4.amt_out;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: whole-amount shift computed in one go.
  function automatic logic [31:0] refShift(input logic [2:0] op, input int n, input logic [31:0] d);
    logic [31:0] r = d;
    case (op)
      3'd1: r = d << n;
      3'd2: r = d >> n;
      3'd3: r = $signed(d) >>> n;
      3'd4: for (int j = 0; j < n; j++) r = {r[0], r[31:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int refAmt(input logic [1:0] sel, input logic [4:0] imm, input logic [4:0] rg);
    if (sel == 2'b00) return int'(imm);
    if (sel == 2'b01) return int'(rg);
    return 16;
  endfunction

  function automatic int refLat(input logic [2:0] op, input int n, input int step);
    if (op == 3'd0 || op > 3'd4 || n == 0) return 0;
    return (n + step - 1) / step;
  endfunction

  // Called at a negedge with the DUT idle or in DONE; returns at the negedge
  // where done is seen (b2b) or one cycle later (otherwise).
  task automatic applyStimulus(input int i, input logic [1:0] sel, input logic [4:0] imm,
                               input logic [4:0] rg, input logic [2:0] op,
                               input logic [31:0] d, input bit b2b);
    int n = refAmt(sel, imm, rg);
    int lat = refLat(op, n, (i == 0) ? 1 : 4);
    logic [31:0] expData = refShift(op, n, d);
    int busyCnt = 0;
    int c = 1;
    bit seen = 0;
    selR[i] = sel; immR[i] = imm; regR[i] = rg; opR[i] = op; dataR[i] = d;
    startR[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    startR[i] = 1'b0;
    while (c <= 70 && !seen) begin
      if (doneW[i]) begin
        seen = 1;
        checkOutput($sformatf("d%0d latency", i), 32'(c), 32'(lat + 1));
        checkOutput($sformatf("d%0d busyCycles", i), 32'(busyCnt), 32'(lat));
        checkOutput($sformatf("d%0d data_out", i), outW[i], expData);
        checkOutput($sformatf("d%0d amt_out", i), {27'd0, amtW[i]}, 32'(n));
        startR[i] = 1'b0;
      end else begin
        if (busyW[i]) busyCnt++;
        startR[i] = busyW[i] ? 1'($urandom) : 1'b0;
        selR[i] = 2'($urandom); immR[i] = 5'($urandom); regR[i] = 5'($urandom);
        opR[i] = 3'($urandom); dataR[i] = $urandom;
        @(negedge clk);
        c++;
      end
    end
    if (!seen) checkOutput($sformatf("d%0d doneTimeout", i), 32'd0, 32'd1);
    if (!b2b) begin
      @(negedge clk);
      checkOutput($sformatf("d%0d donePulse", i), {31'd0, doneW[i]}, 32'd0);
      checkOutput($sformatf("d%0d idleBusy", i), {31'd0, busyW[i]}, 32'd0);
      checkOutput($sformatf("d%0d resultHold", i), outW[i], expData);
    end
  endtask

  task automatic runSuite(input int i);
    applyStimulus(i, 2'b00, 5'd4, 5'd0, 3'd1, 32'h0000_000F, 0);
    applyStimulus(i, 2'b01, 5'd0, 5'd31, 3'd3, 32'h8000_0000, 0);
    applyStimulus(i, 2'b01, 5'd0, 5'd31, 3'd2, 32'h8000_0000, 0);
    applyStimulus(i, 2'b10, 5'd3, 5'd7, 3'd1, 32'h0000_1234, 0);
    applyStimulus(i, 2'b11, 5'd3, 5'd7, 3'd1, 32'h0000_1234, 0);
    applyStimulus(i, 2'b00, 5'd8, 5'd0, 3'd4, 32'h1234_5678, 0);
    applyStimulus(i, 2'b00, 5'd0, 5'd9, 3'd4, 32'hDEAD_BEEF, 0);
    applyStimulus(i, 2'b00, 5'd10, 5'd0, 3'd2, 32'hFFFF_0000, 1);
    applyStimulus(i, 2'b00, 5'd3, 5'd0, 3'd1, 32'h0000_0001, 0);
    applyStimulus(i, 2'b01, 5'd5, 5'd12, 3'd6, 32'hCAFE_F00D, 0);
    for (int t = 0; t < 40; t++) begin
      applyStimulus(i, 2'($urandom), 5'($urandom), 5'($urandom), 3'($urandom_range(0, 7)),
                    $urandom, 1'($urandom));
    end
    applyStimulus(i, 2'b00, 5'd1, 5'd0, 3'd0, 32'h0, 0);
  endtask

  initial begin
    int doneSeen = 0;
    for (int i = 0; i < 2; i++) begin
      startR[i] = 0; selR[i] = 0; immR[i] = 0; regR[i] = 0; opR[i] = 0; dataR[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("d%0d rstBusy", i), {31'd0, busyW[i]}, 32'd0);
      checkOutput($sformatf("d%0d rstDone", i), {31'd0, doneW[i]}, 32'd0);
      checkOutput($sformatf("d%0d rstData", i), outW[i], 32'd0);
      checkOutput($sformatf("d%0d rstAmt", i), {27'd0, amtW[i]}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    fork
      runSuite(0);
      runSuite(1);
    join
    @(negedge clk);

    // Abort a 20-bit shift three cycles in with an asynchronous reset.
    for (int i = 0; i < 2; i++) begin
      selR[i] = 2'b00; immR[i] = 5'd20; opR[i] = 3'd2; dataR[i] = $urandom; startR[i] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    startR[0] = 0; startR[1] = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++)
      checkOutput($sformatf("d%0d midBusy", i), {31'd0, busyW[i]}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("d%0d abortBusy", i), {31'd0, busyW[i]}, 32'd0);
      checkOutput($sformatf("d%0d abortDone", i), {31'd0, doneW[i]}, 32'd0);
      checkOutput($sformatf("d%0d abortData", i), outW[i], 32'd0);
      checkOutput($sformatf("d%0d abortAmt", i), {27'd0, amtW[i]}, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (doneW[0] || doneW[1] || busyW[0] || busyW[1]) doneSeen++;
    end
    checkOutput("noDoneAfterAbort", 32'(doneSeen), 32'd0);
    fork
      applyStimulus(0, 2'b01, 5'd0, 5'd20, 3'd2, 32'hF0F0_F0F0, 0);
      applyStimulus(1, 2'b01, 5'd0, 5'd20, 3'd2, 32'hF0F0_F0F0, 0);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
